// File: rtl/gate_model_bist_if.sv
// Bus between the test sequencer / gate model and the BIST wrapper.
// The master side drives the run controls and the gate-model response;
// the slave side (the BIST) drives the stimulus, status and signature.
interface gate_model_bist_if #(
    parameter int unsigned N_IN  = 10,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned PAT_W = 16
);
    logic             start_i;
    logic             abort_i;
    logic             mode_i;
    logic [PAT_W-1:0] num_pat_i;
    logic [N_OUT-1:0] golden_i;
    logic [N_IN-1:0]  stim_o;
    logic [N_OUT-1:0] resp_i;
    logic             busy_o;
    logic             done_o;
    logic [N_OUT-1:0] sig_o;
    logic             pass_o;

    modport master (
        output start_i, abort_i, mode_i, num_pat_i, golden_i, resp_i,
        input  stim_o, busy_o, done_o, sig_o, pass_o
    );

    modport slave (
        input  start_i, abort_i, mode_i, num_pat_i, golden_i, resp_i,
        output stim_o, busy_o, done_o, sig_o, pass_o
    );
endinterface

// File: rtl/gate_model_bist.sv
// BIST wrapper for a combinational gate model: drives LFSR or exhaustive
// stimulus, compacts responses into a MISR and compares against a golden value.
module gate_model_bist #(
    parameter int unsigned      N_IN     = 10,
    parameter int unsigned      N_OUT    = 10,
    parameter int unsigned      PAT_W    = 16,
    parameter logic [N_IN-1:0]  POLY_IN  = 10'h240,
    parameter logic [N_OUT-1:0] POLY_OUT = 10'h240,
    parameter logic [N_IN-1:0]  SEED     = 1
) (
    input logic              clk,
    input logic              rst_n,
    gate_model_bist_if.slave bus_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [N_OUT-1:0] misr_q, misr_d;
    logic [PAT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    // Next-state logic: abort wins over everything, start only from IDLE/DONE.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (bus_io.abort_i) begin
            // Signature is deliberately kept so it can be inspected after abort.
            state_d = StIdle;
            stim_d  = '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (bus_io.start_i) begin
                        misr_d  = '0;
                        stim_d  = bus_io.mode_i ? '0 : SEED;
                        cnt_d   = bus_io.num_pat_i;
                        mode_d  = bus_io.mode_i;
                        state_d = (bus_io.num_pat_i != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    misr_d = {misr_q[N_OUT-2:0], ^(misr_q & POLY_OUT)} ^ bus_io.resp_i;
                    if (cnt_q == PAT_W'(1)) begin
                        // Last pattern: hold stim so the final pattern stays visible.
                        state_d = StDone;
                    end else begin
                        cnt_d  = cnt_q - PAT_W'(1);
                        stim_d = mode_q ? stim_q + N_IN'(1)
                                        : {stim_q[N_IN-2:0], ^(stim_q & POLY_IN)};
                    end
                end
                default: begin
                    state_d = StIdle;
                    stim_d  = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stim_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign bus_io.stim_o = stim_q;
    assign bus_io.sig_o  = misr_q;
    assign bus_io.busy_o = (state_q == StRun);
    assign bus_io.done_o = (state_q == StDone);
    assign bus_io.pass_o = (state_q == StDone) && (misr_q == bus_io.golden_i);
endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist with a 4-in/4-out toy gate model.
module tb_gate_model_bist;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    gate_model_bist_if #(.N_IN(4), .N_OUT(4), .PAT_W(16)) bus ();

    gate_model_bist #(
        .N_IN    (4),
        .N_OUT   (4),
        .PAT_W   (16),
        .POLY_IN (4'b1100),
        .POLY_OUT(4'b1100),
        .SEED    (4'b0001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       resp_const_en = 1'b1;
    logic [3:0] resp_const    = 4'b0000;
    logic [3:0] exp_sig;
    logic [3:0] exp_q[$];

    // Expected LFSR period for taps 1100 from seed 0001.
    logic [3:0] lfsr_tab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                  4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // Toy combinational gate model under test.
    function automatic logic [3:0] gate_fn(input logic [3:0] s);
        return {s[0] & s[1], s[1] | s[2], s[2] ^ s[3], ~s[0]};
    endfunction

    function automatic logic [3:0] resp_model(input logic [3:0] s);
        return resp_const_en ? resp_const : gate_fn(s);
    endfunction

    assign bus.resp_i = resp_const_en ? resp_const : gate_fn(bus.stim_o);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Start a run, compare every pattern against the scoreboard, then check the result.
    task automatic run_bist(input logic m, input int n, input bit poke);
        logic [3:0] pat;
        logic [3:0] misr;
        logic [3:0] last;
        int         cyc;
        exp_q.delete();
        misr = 4'b0000;
        last = m ? 4'b0000 : 4'b0001;
        for (int p = 0; p < n; p++) begin
            pat = m ? 4'(p) : lfsr_tab[p % 15];
            exp_q.push_back(pat);
            misr = {misr[2:0], ^(misr & 4'b1100)} ^ resp_model(pat);
            last = pat;
        end
        exp_sig          = misr;
        bus.golden_i     = misr;
        bus.mode_i       = m;
        bus.num_pat_i    = 16'(n);
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i   = 1'b0;
        bus.mode_i    = ~m;
        bus.num_pat_i = 16'd3;
        cyc = 1;
        if (n > 0) begin
            check_eq("busy_rise", 32'(bus.busy_o), 32'd1);
            check_eq("done_drop", 32'(bus.done_o), 32'd0);
        end
        while (!bus.done_o && cyc < n + 10) begin
            if (exp_q.size() == 0) check_eq("stim_extra", 32'(bus.busy_o), 32'd0);
            else check_eq("stim", 32'(bus.stim_o), 32'(exp_q.pop_front()));
            check_eq("pass_busy", 32'(bus.pass_o), 32'd0);
            if (poke && cyc == 3) begin
                bus.start_i   = 1'b1;
                bus.num_pat_i = 16'd2;
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start_i = 1'b0;
        check_eq("latency", 32'(cyc), 32'(n + 1));
        check_eq("done", 32'(bus.done_o), 32'd1);
        check_eq("busy_fall", 32'(bus.busy_o), 32'd0);
        check_eq("sig", 32'(bus.sig_o), 32'(exp_sig));
        check_eq("stim_hold", 32'(bus.stim_o), 32'(last));
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("pass_hi", 32'(bus.pass_o), 32'd1);
        bus.golden_i = exp_sig ^ 4'b1000;
        #1;
        check_eq("pass_lo", 32'(bus.pass_o), 32'd0);
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.mode_i    = 1'b0;
        bus.num_pat_i = '0;
        bus.golden_i  = '0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_stim", 32'(bus.stim_o), 32'd0);
        check_eq("rst_sig", 32'(bus.sig_o), 32'd0);
        check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("rst_done", 32'(bus.done_o), 32'd0);
        check_eq("rst_pass", 32'(bus.pass_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MISR arithmetic with a constant response, second run back-to-back from DONE.
        resp_const_en = 1'b1;
        resp_const    = 4'b0101;
        run_bist(1'b0, 1, 1'b0);
        check_eq("misr_1", 32'(bus.sig_o), 32'h5);
        run_bist(1'b0, 2, 1'b0);
        check_eq("misr_2", 32'(bus.sig_o), 32'hE);
        bus.golden_i = 4'b1110;
        #1 check_eq("pass_1110", 32'(bus.pass_o), 32'd1);
        bus.golden_i = 4'b1111;
        #1 check_eq("pass_1111", 32'(bus.pass_o), 32'd0);

        // Full LFSR period plus wrap, driven through the gate model.
        resp_const_en = 1'b0;
        run_bist(1'b0, 16, 1'b0);

        // Exhaustive count with wrap and zero response.
        resp_const_en = 1'b1;
        resp_const    = 4'b0000;
        run_bist(1'b1, 18, 1'b0);
        check_eq("exh_final", 32'(bus.stim_o), 32'd1);
        check_eq("exh_sig", 32'(bus.sig_o), 32'd0);

        // Zero-pattern runs in both modes.
        run_bist(1'b0, 0, 1'b0);
        run_bist(1'b1, 0, 1'b0);

        // Start during RUN must be ignored.
        resp_const_en = 1'b0;
        run_bist(1'b0, 8, 1'b1);

        // Abort together with start while in DONE.
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        check_eq("abort_done", 32'(bus.done_o), 32'd0);
        check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
        check_eq("abort_stim", 32'(bus.stim_o), 32'd0);
        check_eq("abort_sig", 32'(bus.sig_o), 32'(exp_sig));
        @(posedge clk);
        #1;
        check_eq("abort_idle", 32'(bus.done_o | bus.busy_o), 32'd0);

        // Reset in the third RUN cycle.
        bus.mode_i    = 1'b0;
        bus.num_pat_i = 16'd8;
        bus.start_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_stim", 32'(bus.stim_o), 32'd0);
        check_eq("mrst_sig", 32'(bus.sig_o), 32'd0);
        check_eq("mrst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("mrst_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_after_rst", 32'(bus.done_o | bus.busy_o), 32'd0);
        run_bist(1'b0, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gate_model_bist.md
# gate_model_bist

Parametrised built-in self-test wrapper for the combinational gate models in the gate library. It drives a model's inputs with pseudo-random (LFSR) or exhaustive patterns and compacts the model's outputs into a multiple-input signature register (MISR). It then compares the signature against a golden value. It sits between the simulator's test sequencer and any N_IN-input / N_OUT-output gate model.

## Interface
Parameters:
- N_IN, 10: gate-model input count (stimulus width), ≥2.
- N_OUT, 10: gate-model output count (signature width), ≥2.
- PAT_W, 16: pattern-count width.
- POLY_IN, 10'h240: LFSR feedback tap mask, N_IN bits.
- POLY_OUT, 10'h240: MISR feedback tap mask, N_OUT bits.
- SEED, 1: LFSR start value, N_IN bits, must be nonzero.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start_i, input, 1: begin a run; honoured only in IDLE or DONE.
- abort_i, input, 1: return to IDLE from any state.
- mode_i, input, 1: 0 = LFSR patterns, 1 = exhaustive binary count; sampled with start.
- num_pat_i, input, PAT_W: number of patterns; sampled with start.
- golden_i, input, N_OUT: expected signature.
- stim_o, output, N_IN: gate-model inputs.
- resp_i, input, N_OUT: gate-model outputs. Combinational from stim_o; settles within one cycle.
- busy_o, output, 1: run in progress.
- done_o, output, 1: run complete; level, held until next start or abort.
- sig_o, output, N_OUT: MISR contents.
- pass_o, output, 1: sig_o == golden_i while done_o = 1, else 0.

## Operation
- The block has three states: IDLE, RUN and DONE. After reset it is in IDLE with stim_o = 0, sig_o = 0, busy_o = 0, done_o = 0 and pass_o = 0.
- When start_i is sampled high in IDLE or DONE:
  - misr ← 0.
  - stim ← SEED in LFSR mode, or 0 in exhaustive mode.
  - cnt ← num_pat_i.
  - mode is latched.
  - Next state is RUN if num_pat_i ≠ 0. Otherwise next state is DONE, with sig_o = 0.
- Each RUN cycle:
  - misr ← {misr[N_OUT-2:0], ^(misr & POLY_OUT)} ^ resp_i.
  - If cnt == 1, go to DONE and hold stim.
  - Otherwise cnt ← cnt−1 and stim advances:
    - LFSR mode: stim ← {stim[N_IN-2:0], ^(stim & POLY_IN)}.
    - Exhaustive mode: stim ← stim+1, modulo 2^N_IN. Runs longer than 2^N_IN wrap around and repeat patterns.
- start_i is ignored in RUN. Changes to mode_i and num_pat_i during RUN have no effect.
- DONE holds sig_o and stim_o. pass_o is combinational on the registered sig_o and golden_i.
- abort_i has priority over start_i and takes effect from any state. It forces IDLE with stim_o = 0, busy_o = 0 and done_o = 0; sig_o keeps its value.
- rst_n low forces the reset values immediately, including mid-RUN. Operation resumes in IDLE after the first rising clk with rst_n high.

## Timing
- Start sampled at edge k: busy_o = 1 and stim_o = first pattern from edge k+1 onward.
- Pattern p (p = 0 … num_pat−1) is on stim_o during cycle k+1+p. Its resp_i is absorbed into the MISR at edge k+2+p.
- done_o rises, busy_o falls and the final sig_o is valid at edge k+1+num_pat. Total latency is num_pat+1 cycles.
- num_pat_i = 0: done_o = 1 at edge k+1, sig_o = 0, busy_o never asserted.
- A start in DONE restarts at edge k. done_o drops at edge k+1 together with busy_o rising. Runs are back-to-back with no idle cycle.
- All outputs are registered except pass_o.

## Test plan
All scenarios use N_IN = N_OUT = 4, POLY_IN = POLY_OUT = 4'b1100, SEED = 4'b0001.
- Reset mid-run: start, num_pat = 8, pull rst_n low in the 3rd RUN cycle. Required: immediately stim_o = 0, sig_o = 0, busy_o = 0, done_o = 0. After release, IDLE; a new start runs normally.
- LFSR sequence: mode 0, num_pat = 16. Required stim_o sequence: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then 0001 (period 15). done_o rises 17 cycles after the start edge.
- MISR arithmetic: resp_i held at 0101. With num_pat = 1, sig_o = 0101; with num_pat = 2, sig_o = 1110. With golden_i = 1110, pass_o = 1; with golden_i = 1111, pass_o = 0.
- Exhaustive mode with wrap: mode 1, num_pat = 18. Required: stim_o = 0…15, then 0, 1; final stim_o = 0001; resp_i = 0 gives sig_o = 0000.
- Boundaries: num_pat = 0 gives done_o next cycle with sig_o = 0. start during RUN is ignored (cycle count unchanged). abort_i asserted together with start_i in DONE leads to IDLE, done_o = 0.
